// File: rtl/ixu_pkg.sv
// Shared types and sizing for the integer register file and the writeback lanes.
package ixu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        logic      wr_en;
        reg_addr_t rd;
        reg_data_t data;
    } wb_req_t;

    // x0 is architecturally constant, so any access aimed at it carries no effect.
    function automatic logic is_live(input logic en, input reg_addr_t idx);
        return en && (idx != '0);
    endfunction

endpackage

// File: rtl/ixu_scoreboard.sv
// Per-register pending tracker: issue sets, writeback clears, issue wins on a same-cycle tie.
module ixu_scoreboard
    import ixu_pkg::*;
#(
    parameter int NUM_WB = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic      [NUM_WB-1:0]           wb_wr_en,
    input  logic      [NUM_WB-1:0][ADDR_W-1:0] wb_rd,
    input  logic      [NUM_WB-1:0]           iss_en,
    input  logic      [NUM_WB-1:0][ADDR_W-1:0] iss_rd,
    output logic      [NUM_REGS-1:0]         busy_vec,
    output logic      [NUM_REGS-1:0]         pending_nxt
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        for (int l = 0; l < NUM_WB; l++) begin
            if (is_live(wb_wr_en[l], wb_rd[l])) begin
                pending_d[wb_rd[l]] = 1'b0;
            end
        end
        // Sets are applied after clears: the issuing instruction is younger.
        for (int l = 0; l < NUM_WB; l++) begin
            if (is_live(iss_en[l], iss_rd[l])) begin
                pending_d[iss_rd[l]] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign busy_vec    = pending_q;
    assign pending_nxt = pending_d;

endmodule

// File: rtl/ixu_regfile.sv
// Integer register file: merged multi-lane writeback, write-first registered reads, pending scoreboard.
module ixu_regfile
    import ixu_pkg::*;
#(
    parameter int NUM_WB = 2,
    parameter int NUM_RD = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic      [NUM_WB-1:0]           wb_wr_en,
    input  logic      [NUM_WB-1:0][ADDR_W-1:0] wb_rd,
    input  logic      [NUM_WB-1:0][DATA_W-1:0] wb_data,
    input  logic      [NUM_WB-1:0]           iss_en,
    input  logic      [NUM_WB-1:0][ADDR_W-1:0] iss_rd,
    input  logic      [NUM_RD-1:0]           rd_en,
    input  logic      [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
    output logic      [NUM_RD-1:0][DATA_W-1:0] rd_data,
    output logic      [NUM_RD-1:0]           rd_busy,
    output logic      [NUM_REGS-1:0]         busy_vec,
    output logic                             wb_collision
);

    wb_req_t             wb_req [NUM_WB];
    logic [NUM_REGS-1:0] wr_mask;
    reg_data_t           wr_val [NUM_REGS];
    logic                collision_d;
    logic                collision_q;

    reg_data_t           regs_q [NUM_REGS];
    reg_data_t           regs_d [NUM_REGS];

    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_d;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q;
    logic [NUM_RD-1:0]             rd_busy_d;
    logic [NUM_RD-1:0]             rd_busy_q;

    logic [NUM_REGS-1:0] pending_nxt;

    always_comb begin
        for (int l = 0; l < NUM_WB; l++) begin
            wb_req[l].wr_en = wb_wr_en[l];
            wb_req[l].rd    = wb_rd[l];
            wb_req[l].data  = wb_data[l];
        end
    end

    // Lanes are walked low to high so the highest-numbered lane's data is what remains.
    always_comb begin
        wr_mask     = '0;
        collision_d = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_val[r] = '0;
        end
        for (int l = 0; l < NUM_WB; l++) begin
            if (is_live(wb_req[l].wr_en, wb_req[l].rd)) begin
                if (wr_mask[wb_req[l].rd]) begin
                    collision_d = 1'b1;
                end
                wr_mask[wb_req[l].rd] = 1'b1;
                wr_val[wb_req[l].rd]  = wb_req[l].data;
            end
        end
    end

    // wr_mask[0] can never be set, so x0 keeps its reset value of zero.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = wr_mask[r] ? wr_val[r] : regs_q[r];
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) begin
                rd_data_d[p] = regs_d[rd_addr[p]];
                rd_busy_d[p] = pending_nxt[rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            rd_data_q   <= '0;
            rd_busy_q   <= '0;
            collision_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            rd_data_q   <= rd_data_d;
            rd_busy_q   <= rd_busy_d;
            collision_q <= collision_d;
        end
    end

    ixu_scoreboard #(
        .NUM_WB (NUM_WB)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wb_wr_en    (wb_wr_en),
        .wb_rd       (wb_rd),
        .iss_en      (iss_en),
        .iss_rd      (iss_rd),
        .busy_vec    (busy_vec),
        .pending_nxt (pending_nxt)
    );

    assign rd_data      = rd_data_q;
    assign rd_busy      = rd_busy_q;
    assign wb_collision = collision_q;

endmodule

// File: tb/tb_ixu_regfile.sv
// Self-checking bench for ixu_regfile: directed scenarios plus random traffic against a lane-ordered model.
module tb_ixu_regfile;

    logic                  clk;
    logic                  rst;
    logic [1:0]            wb_wr_en;
    logic [1:0][4:0]       wb_rd;
    logic [1:0][31:0]      wb_data;
    logic [1:0]            iss_en;
    logic [1:0][4:0]       iss_rd;
    logic [3:0]            rd_en;
    logic [3:0][4:0]       rd_addr;
    logic [3:0][31:0]      rd_data;
    logic [3:0]            rd_busy;
    logic [31:0]           busy_vec;
    logic                  wb_collision;

    ixu_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .wb_wr_en     (wb_wr_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .iss_en       (iss_en),
        .iss_rd       (iss_rd),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .busy_vec     (busy_vec),
        .wb_collision (wb_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: architectural registers, pending bits and expected registered outputs.
    logic [31:0] m_regs [32];
    logic        m_pend [32];
    logic [31:0] m_rd   [4];
    logic        m_busy [4];
    logic        m_coll;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int p = 0; p < 4; p++) begin
            m_rd[p]   = '0;
            m_busy[p] = 1'b0;
        end
        m_coll = 1'b0;
    endtask

    task automatic model_edge();
        int hits [32];
        for (int i = 0; i < 32; i++) hits[i] = 0;
        m_coll = 1'b0;
        for (int l = 0; l < 2; l++) begin
            if (wb_wr_en[l] && wb_rd[l] != 0) begin
                hits[wb_rd[l]]++;
                m_regs[wb_rd[l]] = wb_data[l];
                m_pend[wb_rd[l]] = 1'b0;
            end
        end
        for (int i = 0; i < 32; i++) if (hits[i] >= 2) m_coll = 1'b1;
        for (int l = 0; l < 2; l++) begin
            if (iss_en[l] && iss_rd[l] != 0) m_pend[iss_rd[l]] = 1'b1;
        end
        for (int p = 0; p < 4; p++) begin
            if (rd_en[p]) begin
                m_rd[p]   = (rd_addr[p] == 0) ? 32'h0 : m_regs[rd_addr[p]];
                m_busy[p] = (rd_addr[p] == 0) ? 1'b0 : m_pend[rd_addr[p]];
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_vec;
        for (int i = 0; i < 32; i++) exp_vec[i] = m_pend[i];
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rd_data[%0d]", p), {32'h0, rd_data[p]}, {32'h0, m_rd[p]});
            chk($sformatf("rd_busy[%0d]", p), {63'h0, rd_busy[p]}, {63'h0, m_busy[p]});
        end
        chk("busy_vec", {32'h0, busy_vec}, {32'h0, exp_vec});
        chk("wb_collision", {63'h0, wb_collision}, {63'h0, m_coll});
    endtask

    task automatic idle();
        wb_wr_en = '0; wb_rd = '0; wb_data = '0;
        iss_en = '0; iss_rd = '0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic set_wb(input int l, input logic [4:0] rd, input logic [31:0] d);
        wb_wr_en[l] = 1'b1; wb_rd[l] = rd; wb_data[l] = d;
    endtask

    task automatic set_iss(input int l, input logic [4:0] rd);
        iss_en[l] = 1'b1; iss_rd[l] = rd;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1; rd_addr[p] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // Every register reads zero and idle after reset.
        for (int c = 0; c < 8; c++) begin
            idle();
            for (int p = 0; p < 4; p++) set_rd(p, 5'(c * 4 + p));
            tick();
        end

        // Same-cycle write then read returns the new value.
        idle(); set_wb(0, 5'd3, 32'h12345678); set_rd(0, 5'd3);
        tick();
        chk("bypass_x3", {32'h0, rd_data[0]}, 64'h12345678);
        idle(); set_rd(1, 5'd3);
        tick();
        chk("later_x3", {32'h0, rd_data[1]}, 64'h12345678);

        // Two lanes to one register: lane1 wins, single-cycle collision pulse.
        idle(); set_wb(0, 5'd7, 32'h1111); set_wb(1, 5'd7, 32'h2222);
        tick();
        chk("coll_pulse", {63'h0, wb_collision}, 64'h1);
        idle(); set_rd(2, 5'd7);
        tick();
        chk("coll_drop", {63'h0, wb_collision}, 64'h0);
        chk("x7_lane1", {32'h0, rd_data[2]}, 64'h2222);

        // x0 ignores writes and issues.
        idle(); set_wb(1, 5'd0, 32'hFFFFFFFF); set_iss(1, 5'd0); set_rd(2, 5'd0);
        tick();
        chk("x0_zero", {32'h0, rd_data[2]}, 64'h0);
        idle();
        tick();
        chk("x0_busy", {63'h0, busy_vec[0]}, 64'h0);
        chk("x0_nocoll", {63'h0, wb_collision}, 64'h0);

        // Scoreboard: issue sets, same-cycle reissue beats writeback, lone writeback clears.
        idle(); set_iss(0, 5'd9);
        tick();
        chk("x9_set", {63'h0, busy_vec[9]}, 64'h1);
        idle(); set_wb(1, 5'd9, 32'h99); set_iss(0, 5'd9); set_rd(3, 5'd9);
        tick();
        chk("x9_reissue", {63'h0, busy_vec[9]}, 64'h1);
        chk("x9_rdbusy", {63'h0, rd_busy[3]}, 64'h1);
        idle(); set_wb(1, 5'd9, 32'h9A); set_rd(3, 5'd9);
        tick();
        chk("x9_clear", {63'h0, busy_vec[9]}, 64'h0);
        chk("x9_rdidle", {63'h0, rd_busy[3]}, 64'h0);

        // Read port holds while rd_en is low, even as the register changes.
        idle(); set_rd(0, 5'd3);
        tick();
        idle(); set_wb(0, 5'd3, 32'hABCD0123);
        tick();
        idle();
        tick();
        tick();
        chk("hold_x3", {32'h0, rd_data[0]}, 64'h12345678);
        set_rd(0, 5'd3);
        tick();
        chk("reread_x3", {32'h0, rd_data[0]}, 64'hABCD0123);

        // Reset arriving while a write is staged discards it.
        idle(); set_wb(0, 5'd5, 32'hDEAD); set_iss(1, 5'd6);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1 idle();
        #1 rst = 1'b1;
        set_rd(0, 5'd5); set_rd(1, 5'd3);
        tick();
        chk("x5_reset", {32'h0, rd_data[0]}, 64'h0);

        // Random traffic, biased to a few registers so conflicts and tie cases occur often.
        for (int c = 0; c < 500; c++) begin
            idle();
            for (int l = 0; l < 2; l++) begin
                wb_wr_en[l] = 1'($urandom_range(0, 1));
                wb_rd[l]    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                          : 5'($urandom_range(0, 7));
                wb_data[l]  = $urandom;
                iss_en[l]   = ($urandom_range(0, 2) == 0);
                iss_rd[l]   = 5'($urandom_range(0, 7));
            end
            for (int p = 0; p < 4; p++) begin
                rd_en[p]   = 1'($urandom_range(0, 1));
                rd_addr[p] = 5'($urandom_range(0, 8));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ixu_regfile.md
Name: ixu_regfile

Overview:
- Integer register file for the VLIW integer lanes; receiving end of the lane writeback interface (rd index, data, write enable per lane).
- Accepts one write per writeback lane per cycle and serves registered read ports to the operand-fetch stage.
- Keeps a per-register pending scoreboard: issue sets a register's pending bit; writeback clears it.

Parameters:
- NUM_WB, 2, number of writeback lanes (write ports)
- NUM_RD, 4, number of read ports
- DATA_W, 32, register width
- NUM_REGS, 32, architectural integer registers; x0 is hardwired to zero
- ADDR_W, 5, register index width, equal to log2(NUM_REGS)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- wb_wr_en  in  NUM_WB  per-lane write enable from the writeback stage
- wb_rd  in  NUM_WB x ADDR_W  per-lane destination index
- wb_data  in  NUM_WB x DATA_W  per-lane write data
- iss_en  in  NUM_WB  per-lane issue strobe; marks iss_rd pending
- iss_rd  in  NUM_WB x ADDR_W  per-lane issued destination
- rd_en  in  NUM_RD  read request per port
- rd_addr  in  NUM_RD x ADDR_W  read index per port
- rd_data  out  NUM_RD x DATA_W  registered read data
- rd_busy  out  NUM_RD  registered pending flag of the register read
- busy_vec  out  NUM_REGS  current pending bits; bit 0 is always 0
- wb_collision  out  1  one-cycle pulse when two or more lanes write the same nonzero rd in one cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers are 0 and all pending bits are 0.
  - rd_data and rd_busy are 0; wb_collision is 0.
  - Taking effect mid-operation discards all in-flight writes and issues.
- Writes:
  - At the rising edge, each lane with wb_wr_en=1 and wb_rd!=0 writes wb_data into reg[wb_rd].
  - A write to index 0 is ignored.
  - wb_wr_en=0 with any rd/data is a no-op. NOP slots arrive as rd=0, data=0, en=0.
- Write conflict:
  - If several lanes target the same nonzero rd, the highest-numbered lane wins.
  - wb_collision=1 in the following cycle for exactly one cycle.
- Reads (latency 1):
  - When rd_en[p]=1 at an edge, rd_data[p] is loaded with the value of rd_addr[p] after that edge's writes, i.e. write-first bypass using the highest-lane-wins data.
  - rd_addr=0 always returns 0.
  - When rd_en[p]=0, rd_data[p] and rd_busy[p] hold their previous values.
- Scoreboard:
  - At the edge, each enabled writeback with nonzero rd clears pending[rd].
  - Each iss_en lane with nonzero iss_rd sets pending[iss_rd].
  - Set and clear of the same register in the same cycle: set wins, since the issue is younger.
  - Issue to index 0 is ignored.
  - A writeback to a non-pending register still writes the data; pending stays 0 and no error is flagged.
- rd_busy[p]: when rd_en[p]=1, it is loaded with pending[rd_addr[p]] after that edge's updates.
- busy_vec is the registered pending vector, with no combinational path from inputs.
- No backpressure: every writeback and issue is accepted every cycle.
- Multiple reads of the same address in one cycle are all served.

Decomposition:
- Package ixu_pkg:
  - constants DATA_W, ADDR_W, NUM_REGS
  - typedefs reg_addr_t, reg_data_t
  - struct wb_req_t {wr_en, rd, data}, shared with ixu_writeback outputs
- Sub-module ixu_scoreboard:
  - owns the pending vector, set/clear priority, and the x0 exclusion.
  - exports busy_vec and a next-state pending vector for the rd_busy lookup.
- Write-merge (highest-lane priority plus collision detect) stays as a combinational block inside ixu_regfile.

Test Plan:
- Reset, then read all 32 registers on all ports -> rd_data=0, rd_busy=0, busy_vec=0. Assert rst mid-write of x5=0xDEAD -> x5 reads 0.
- Lane0 writes x3=0x12345678; same cycle port0 reads x3 -> next cycle rd_data[0]=0x12345678 (bypass). Later read also returns 0x12345678.
- Lane0 x7=0x1111 and lane1 x7=0x2222 in the same cycle -> x7 reads 0x2222; wb_collision=1 for one cycle, then 0.
- Write x0=0xFFFFFFFF on lane1 with iss_rd=0 -> x0 reads 0, busy_vec[0]=0, no collision pulse.
- Issue x9 on lane0 -> busy_vec[9]=1. Writeback x9 on lane1 while lane0 re-issues x9 in the same cycle -> busy_vec[9] stays 1. Next writeback alone -> busy_vec[9]=0.
- rd_en low for 3 cycles after reading x3 while x3 is overwritten -> rd_data holds the old value until rd_en is reasserted.
